// File: rtl/ps2_scan.sv
// PS/2 keyboard scan-code receiver. It synchronises the PS/2 bus, assembles 11-bit frames
// and tracks make/break state for the last key pressed.
module ps2_scan #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] ps2_byte_o,
    output logic       ps2_state_o,
    output logic       ps2_valid_o,
    output logic       ps2_err_o
);

    localparam int              TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_ZERO    = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE     = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      BIT_START  = 4'd0;
    localparam logic [3:0]      BIT_STOP   = 4'd10;
    localparam logic [7:0]      CODE_BREAK = 8'hF0;
    localparam logic [7:0]      CODE_EXT   = 8'hE0;

    // Data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    logic            ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_dly_q;
    logic            ps2_data_meta_q, ps2_data_sync_q;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [8:0]      shift_q, shift_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            state_q, state_d;
    logic            brk_q, brk_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            fall_s;
    logic            frame_ok_s;

    // Two-flop synchronisers plus a delayed clock copy for edge detection; idle bus is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_dly_q   <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk_i;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_dly_q   <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data_i;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign fall_s     = ps2_clk_dly_q & ~ps2_clk_sync_q;
    assign frame_ok_s = odd_parity_ok(shift_q) & ps2_data_sync_q;

    // Frame assembly, idle timeout and make/break decoding.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        byte_d    = byte_q;
        state_d   = state_q;
        brk_d     = brk_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (fall_s) begin
            to_cnt_d = TO_ZERO;
            case (bit_cnt_q)
                BIT_START: begin
                    // A high start bit is treated as line noise and silently dropped.
                    if (!ps2_data_sync_q) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        bit_cnt_d = BIT_START;
                    end
                end
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                    shift_d   = {ps2_data_sync_q, shift_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                BIT_STOP: begin
                    bit_cnt_d = BIT_START;
                    if (!frame_ok_s) begin
                        err_d = 1'b1;
                    end else if (shift_q[7:0] == CODE_EXT) begin
                        brk_d = brk_q;
                    end else if (shift_q[7:0] == CODE_BREAK) begin
                        brk_d = 1'b1;
                    end else if (brk_q) begin
                        brk_d   = 1'b0;
                        state_d = 1'b0;
                    end else begin
                        byte_d  = shift_q[7:0];
                        state_d = 1'b1;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    bit_cnt_d = BIT_START;
                end
            endcase
        end else if (bit_cnt_q != BIT_START) begin
            if (to_cnt_q == TO_LAST) begin
                bit_cnt_d = BIT_START;
                to_cnt_d  = TO_ZERO;
                err_d     = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_ONE;
            end
        end else begin
            to_cnt_d = TO_ZERO;
        end
    end

    // Receiver state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= 9'd0;
            to_cnt_q  <= TO_ZERO;
            byte_q    <= 8'h00;
            state_q   <= 1'b0;
            brk_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            to_cnt_q  <= to_cnt_d;
            byte_q    <= byte_d;
            state_q   <= state_d;
            brk_q     <= brk_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign ps2_byte_o  = byte_q;
    assign ps2_state_o = state_q;
    assign ps2_valid_o = valid_q;
    assign ps2_err_o   = err_q;

endmodule

// File: tb/tb_ps2_scan.sv
// Directed bench for ps2_scan: hand-built PS/2 frames with expected outputs and pulse counts.
module tb_ps2_scan;

    localparam int TO = 300;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ps2_byte;
    logic       ps2_state;
    logic       ps2_valid;
    logic       ps2_err;

    int n_checks = 0;
    int n_pass   = 0;
    int vcnt     = 0;
    int ecnt     = 0;
    int both     = 0;
    int v0, e0;

    ps2_scan #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .ps2_byte_o (ps2_byte),
        .ps2_state_o(ps2_state),
        .ps2_valid_o(ps2_valid),
        .ps2_err_o  (ps2_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ps2_valid) vcnt++;
            if (ps2_err) ecnt++;
            if (ps2_valid && ps2_err) both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1 ps2_data = b;
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (8) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // Sends the first nbits of a frame; gap idles extra clk cycles after bit 3.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits, input int gap);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(f[i]);
            if (i == 3) repeat (gap) @(posedge clk);
        end
    endtask

    task automatic mark();
        v0 = vcnt;
        e0 = ecnt;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_byte",  32'(ps2_byte),  32'h00);
        check("rst_state", 32'(ps2_state), 32'h0);
        check("rst_valid", 32'(ps2_valid), 32'h0);
        check("rst_err",   32'(ps2_err),   32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // 0x16 with an exact latency probe on the stop-bit edge
        mark();
        send_frame(8'h16, 1'b0, 10, 0);
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b0;
        @(negedge clk); check("lat_c1", 32'(ps2_valid), 32'h0);
        @(negedge clk); check("lat_c2", 32'(ps2_valid), 32'h0);
        @(negedge clk); check("lat_c3", 32'(ps2_valid), 32'h0);
        @(negedge clk); check("lat_c4", 32'(ps2_valid), 32'h1);
        @(negedge clk); check("lat_c5", 32'(ps2_valid), 32'h0);
        repeat (4) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (3) @(posedge clk);
        settle();
        check("m16_byte",  32'(ps2_byte),  32'h16);
        check("m16_state", 32'(ps2_state), 32'h1);
        check("m16_vcnt",  32'(vcnt - v0), 32'd1);
        check("m16_ecnt",  32'(ecnt - e0), 32'd0);

        // break sequence F0 16
        mark();
        send_frame(8'hF0, 1'b0, 11, 0);
        settle();
        check("f0_state",  32'(ps2_state), 32'h1);
        send_frame(8'h16, 1'b0, 11, 0);
        settle();
        check("brk_state", 32'(ps2_state), 32'h0);
        check("brk_byte",  32'(ps2_byte),  32'h16);
        check("brk_vcnt",  32'(vcnt - v0), 32'd0);

        // 0x1E with wrong parity
        mark();
        send_frame(8'h1E, 1'b1, 11, 0);
        settle();
        check("par_ecnt",  32'(ecnt - e0), 32'd1);
        check("par_byte",  32'(ps2_byte),  32'h16);
        check("par_state", 32'(ps2_state), 32'h0);
        check("par_vcnt",  32'(vcnt - v0), 32'd0);

        // noise edge with high start bit, then 0x1C
        mark();
        send_bit(1'b1);
        send_frame(8'h1C, 1'b0, 11, 0);
        settle();
        check("noise_ecnt", 32'(ecnt - e0), 32'd0);
        check("noise_byte", 32'(ps2_byte),  32'h1C);
        check("noise_vcnt", 32'(vcnt - v0), 32'd1);

        // long but sub-timeout gap mid-frame
        mark();
        send_frame(8'h2E, 1'b0, 11, TO - 30);
        settle();
        check("gap_ecnt", 32'(ecnt - e0), 32'd0);
        check("gap_byte", 32'(ps2_byte),  32'h2E);

        // timeout after 5 bits, then 0x25
        mark();
        send_frame(8'h33, 1'b0, 5, 0);
        repeat (TO + 10) @(posedge clk);
        settle();
        check("to_ecnt", 32'(ecnt - e0), 32'd1);
        check("to_vcnt", 32'(vcnt - v0), 32'd0);
        send_frame(8'h25, 1'b0, 11, 0);
        settle();
        check("to_byte",  32'(ps2_byte),  32'h25);
        check("to_vcnt2", 32'(vcnt - v0), 32'd1);
        check("to_ecnt2", 32'(ecnt - e0), 32'd1);

        // extended prefix E0 75, then E0 F0 75
        mark();
        send_frame(8'hE0, 1'b0, 11, 0);
        send_frame(8'h75, 1'b0, 11, 0);
        settle();
        check("ext_byte",  32'(ps2_byte),  32'h75);
        check("ext_state", 32'(ps2_state), 32'h1);
        check("ext_vcnt",  32'(vcnt - v0), 32'd1);
        mark();
        send_frame(8'hE0, 1'b0, 11, 0);
        send_frame(8'hF0, 1'b0, 11, 0);
        send_frame(8'h75, 1'b0, 11, 0);
        settle();
        check("extbrk_state", 32'(ps2_state), 32'h0);
        check("extbrk_byte",  32'(ps2_byte),  32'h75);
        check("extbrk_vcnt",  32'(vcnt - v0), 32'd0);

        // typematic repeats
        mark();
        send_frame(8'h1D, 1'b0, 11, 0);
        send_frame(8'h1D, 1'b0, 11, 0);
        settle();
        check("rep_vcnt", 32'(vcnt - v0), 32'd2);
        check("rep_byte", 32'(ps2_byte),  32'h1D);

        // reset mid-frame of 0x45, then 0x26
        send_frame(8'h45, 1'b0, 5, 0);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_byte",  32'(ps2_byte),  32'h00);
        check("mrst_state", 32'(ps2_state), 32'h0);
        check("mrst_valid", 32'(ps2_valid), 32'h0);
        check("mrst_err",   32'(ps2_err),   32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        mark();
        send_frame(8'h26, 1'b0, 11, 0);
        settle();
        check("post_byte",  32'(ps2_byte),  32'h26);
        check("post_state", 32'(ps2_state), 32'h1);
        check("post_ecnt",  32'(ecnt - e0), 32'd0);
        check("post_vcnt",  32'(vcnt - v0), 32'd1);

        check("no_overlap", 32'(both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
